// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared definitions for the iterative multiply/divide unit:
//                operation encodings, FSM state type, divide-by-zero constant.
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    // Operation encodings presented on the op bus by the decoder
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FIXUP = 2'd2
    } md_state_t;

    // LO value reported for a divide whose divisor is zero
    localparam logic [MD_WIDTH-1:0] DIV0_LO = '1;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_if
//  Description : Decoder <-> multiply/divide unit bundle. master = decoder
//                side, slave = muldiv_unit side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             rd_req;
    logic             flush;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall;
    logic             done;
    logic             div0;

    modport master (
        output start, op, rs_val, rt_val, mthi, mtlo, wdata, rd_req, flush,
        input  hi, lo, busy, stall, done, div0
    );

    modport slave (
        input  start, op, rs_val, rt_val, mthi, mtlo, wdata, rd_req, flush,
        output hi, lo, busy, stall, done, div0
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_core.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_core
//  Description : Iteration datapath for muldiv_unit. Shift-add multiply into a
//                2*WIDTH accumulator, restoring shift-subtract divide with
//                {remainder, quotient} sharing the same accumulator, and the
//                final sign correction of the result.
//                Optional: MULDIV_EARLY_OUT_EN enables the multiply early-out
//                indication (remaining multiplier about to become zero).
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,      // capture operands for a new op
    input  logic             step_i,      // perform one iteration
    input  logic             is_div_i,    // class of the op being loaded
    input  logic [WIDTH-1:0] a_mag_i,     // multiplicand / dividend magnitude
    input  logic [WIDTH-1:0] b_mag_i,     // multiplier / divisor magnitude
    input  logic             neg_main_i,  // negate product or quotient
    input  logic             neg_rem_i,   // negate remainder
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             mul_last_o   // this step finishes the multiply
);

    localparam int W2 = 2 * WIDTH;

    logic [W2-1:0]    acc_q, acc_d;
    logic [W2-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;   // multiplier, or divisor for divide
    logic             is_div_q;
    logic             neg_main_q;
    logic             neg_rem_q;

    // Partial remainder with the next dividend bit appended, and trial difference
    logic [WIDTH:0]   w_rem_ext;
    logic [WIDTH:0]   w_diff;
    logic [W2-1:0]    w_acc_neg;
    logic [WIDTH-1:0] w_hi_neg;
    logic [WIDTH-1:0] w_lo_neg;

    assign w_rem_ext = acc_q[W2-1:WIDTH-1];
    assign w_diff    = w_rem_ext - {1'b0, mplier_q};
    assign w_acc_neg = -acc_q;
    assign w_hi_neg  = -acc_q[W2-1:WIDTH];
    assign w_lo_neg  = -acc_q[WIDTH-1:0];

    // Next-state of the working registers: operand load or one iteration
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (load_i) begin
            mplier_d = b_mag_i;
            if (is_div_i) begin
                acc_d   = {{WIDTH{1'b0}}, a_mag_i};
                mcand_d = '0;
            end else begin
                acc_d   = '0;
                mcand_d = {{WIDTH{1'b0}}, a_mag_i};
            end
        end else if (step_i) begin
            if (is_div_q) begin
                // Non-negative trial difference: keep it and set the quotient bit
                if (!w_diff[WIDTH]) begin
                    acc_d = {w_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {w_rem_ext[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = {mcand_q[W2-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            end
        end
    end

    // Working registers and recorded result signs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            is_div_q   <= 1'b0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            if (load_i) begin
                is_div_q   <= is_div_i;
                neg_main_q <= neg_main_i;
                neg_rem_q  <= neg_rem_i;
            end
        end
    end

    // Sign correction: full 2W negate for products, per-half for divides
    always_comb begin
        hi_o = acc_q[W2-1:WIDTH];
        lo_o = acc_q[WIDTH-1:0];
        if (is_div_q) begin
            if (neg_rem_q) begin
                hi_o = w_hi_neg;
            end
            if (neg_main_q) begin
                lo_o = w_lo_neg;
            end
        end else if (neg_main_q) begin
            hi_o = w_acc_neg[W2-1:WIDTH];
            lo_o = w_acc_neg[WIDTH-1:0];
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    // Only bit 0 (or nothing) left in the multiplier: this step is the last
    assign mul_last_o = !is_div_q && (mplier_q[WIDTH-1:1] == '0);
`else
    assign mul_last_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative 32-bit multiply/divide unit owning HI/LO. Holds the
//                control FSM, iteration counter and HI/LO registers; the
//                arithmetic lives in muldiv_core.
//                Optional: MULDIV_EARLY_OUT_EN (multiply early-out).
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic     clk,
    input  logic     reset_n,
    muldiv_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             div0_q, div0_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;   // in-flight op is a divide by 0

    logic             w_load;
    logic             w_step;
    logic             w_is_div;
    logic             w_div0_op;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_neg_main;
    logic             w_neg_rem;
    logic [WIDTH-1:0] w_core_hi;
    logic [WIDTH-1:0] w_core_lo;
    logic             w_core_last;
    logic             w_busy;

    // Operand preparation. A divide by zero loads the raw dividend with no sign
    // correction, so the remainder path hands back rs_val exactly as given.
    assign w_is_div   = op_is_div(bus.op);
    assign w_div0_op  = w_is_div && (bus.rt_val == '0);
    assign w_a_neg    = op_is_signed(bus.op) && bus.rs_val[WIDTH-1];
    assign w_b_neg    = op_is_signed(bus.op) && bus.rt_val[WIDTH-1];
    assign w_a_mag    = (w_a_neg && !w_div0_op) ? -bus.rs_val : bus.rs_val;
    assign w_b_mag    = w_b_neg ? -bus.rt_val : bus.rt_val;
    assign w_neg_main = !w_div0_op && (w_a_neg ^ w_b_neg);
    assign w_neg_rem  = !w_div0_op && w_a_neg;

    muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (w_load),
        .step_i     (w_step),
        .is_div_i   (w_is_div),
        .a_mag_i    (w_a_mag),
        .b_mag_i    (w_b_mag),
        .neg_main_i (w_neg_main),
        .neg_rem_i  (w_neg_rem),
        .hi_o       (w_core_hi),
        .lo_o       (w_core_lo),
        .mul_last_o (w_core_last)
    );

    // Next-state, counter, HI/LO write-back and datapath control
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div0_d     = div0_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        w_load     = 1'b0;
        w_step     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    // start outranks mthi/mtlo; a concurrent flush cancels it
                    if (!bus.flush) begin
                        w_load     = 1'b1;
                        state_d    = ST_RUN;
                        cnt_d      = '0;
                        div0_d     = 1'b0;
                        div_zero_d = w_div0_op;
                    end
                end else begin
                    if (bus.mthi) begin
                        hi_d = bus.wdata;
                    end
                    if (bus.mtlo) begin
                        lo_d = bus.wdata;
                    end
                end
            end
            ST_RUN: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    w_step = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if ((cnt_q == LAST_ITER) || w_core_last) begin
                        state_d = ST_FIXUP;
                    end
                end
            end
            ST_FIXUP: begin
                state_d = ST_IDLE;
                if (!bus.flush) begin
                    hi_d   = w_core_hi;
                    lo_d   = div_zero_q ? WIDTH'(DIV0_LO) : w_core_lo;
                    div0_d = div_zero_q;
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and architectural state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div0_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div0_q     <= div0_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign w_busy    = (state_q != ST_IDLE);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = w_busy;
    assign bus.done  = done_q;
    assign bus.div0  = div0_q;
    assign bus.stall = w_busy && (bus.rd_req || bus.start || bus.mthi || bus.mtlo);

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative 32-bit multiply/divide unit owning the HI/LO register pair.
- Sequenced by the instruction decoder: it issues start/op, MTHI/MTLO and MFHI/MFLO reads.
- Sits beside the ALU in the execute stage.
- Raises a stall to the pipeline when an HI/LO access or a new start hits a busy unit.

Parameters:
- WIDTH, 32, operand width; also the iteration count.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  input  1  clock
- reset_n  input  1  reset, asynchronous, active-low
- start  input  1  begin operation; sampled when unit is idle
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_val  input  WIDTH  multiplicand / dividend
- rt_val  input  WIDTH  multiplier / divisor
- mthi  input  1  write wdata to HI
- mtlo  input  1  write wdata to LO
- wdata  input  WIDTH  MTHI/MTLO data
- rd_req  input  1  decoder has MFHI/MFLO in execute
- flush  input  1  cancel in-flight operation (branch/jump squash)
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  operation in flight
- stall  output  1  equals busy & (rd_req | start | mthi | mtlo)
- done  output  1  one-cycle pulse; HI/LO updated this cycle
- div0  output  1  sticky flag: last divide had divisor 0; cleared by next start

Behaviour:
- Reset: asynchronous, active-low. hi, lo, div0 and done are 0. FSM goes to IDLE and the counter to 0, immediately, including mid-operation.
- FSM states: IDLE, RUN, FIXUP.
- IDLE to RUN on start, unless flush is also high.
  - On entry, latch operand magnitudes: absolute value for signed ops, raw for unsigned.
  - Record result signs: product sign = sign(rs)^sign(rt); quotient likewise; remainder sign = sign(rs).
  - Clear the counter and clear div0.
- RUN performs one iteration per cycle.
  - Multiply: left-shifted multiplicand is added into a 2*WIDTH accumulator when multiplier bit 0 is 1; the multiplier then shifts right.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
  - After WIDTH iterations, go to FIXUP.
- FIXUP, one cycle: apply two's-complement negation per the recorded signs, write HI/LO, pulse done, return to IDLE.
  - Multiply: HI = product[2W-1:W], LO = product[W-1:0].
  - Divide: LO = quotient, HI = remainder.
- Latency: start sampled at edge 0. RUN occupies edges 1..WIDTH. HI/LO and done are visible after edge WIDTH+1, i.e. 33 cycles for WIDTH=32.
- busy is high from edge 0 until HI/LO are written; busy falls in the same cycle that done rises.
- Working registers are separate from hi/lo. hi/lo change only on FIXUP, MTHI/MTLO or reset.
- Divisor 0: div0 = 1, LO = all ones, HI = dividend (rs_val as given). Latency is unchanged.
- DIV 0x80000000 / -1: LO = 0x80000000, HI = 0. No trap.
- flush while busy: return to IDLE next edge. No done pulse; hi/lo are unchanged.
- flush and start in the same idle cycle: flush wins.
- start while busy: ignored; stall is asserted.
- mthi/mtlo while busy: ignored; stall is asserted. In IDLE they write on the next edge.
- Priority in IDLE: start > mthi/mtlo. A simultaneous mthi and mtlo both write.
- rd_req in the done cycle sees the new HI/LO and does not stall.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: multiply leaves RUN for FIXUP at the edge where the remaining multiplier becomes 0 (zero multiplier: FIXUP at edge 1). Divide latency is unchanged.
- Undefined: fixed WIDTH+1 cycle latency for all ops.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - the FSM state enum;
  - the DIV0_LO constant (all ones).
- Sub-module muldiv_core holds the iteration datapath: accumulator, shifter, adder/subtractor, negate logic.
- The FSM, counter and HI/LO registers stay in muldiv_unit.

Test Plan:
- MULT rs=7, rt=0xFFFFFFFD: done after 33 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy low the same cycle.
- DIVU 100/7: lo=14, hi=2. DIV 0xFFFFFFF9/2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 5/0: div0=1, lo=0xFFFFFFFF, hi=5. Next start clears div0.
- rd_req held during MULT: stall=1 every busy cycle, 0 in the done cycle. flush at cycle 10 of a second MULT: busy low next cycle, hi/lo keep the prior result, no done.
- mthi wdata=0x1234 in idle: hi=0x1234 next cycle. mtlo during busy: ignored, stall=1. reset_n low mid-RUN: hi=lo=0 and busy=0 immediately.
- MULTU 3*5 with MULDIV_EARLY_OUT_EN defined: lo=15, done by cycle 4. Without the macro: done at cycle 33.
